stopwatch_counter: RTL and testbench

- Upstream source of the 32-bit `num_to_display` value consumed by the eight-digit 7-segment decimal display driver.
- Takes three raw push-button inputs (start/stop, clear, lap) and synchronizes and debounces them.
- Runs a prescaled ascending decimal-range counter with a small run/pause FSM and presents the count as a binary value for display.

---
 rtl/stopwatch_counter_if.sv | 25 ++
 rtl/stopwatch_counter.sv | 187 ++++++++++++++++++
 tb/tb_stopwatch_counter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_counter_if.sv
// Signal bundle between the stopwatch counter and whatever drives its buttons
// and consumes its display value.
interface stopwatch_counter_if;
    // Buttons are raw levels with no handshake. tick_out and wrap are one-cycle
    // strobes with no back-pressure. num_to_display, running and state_dbg are
    // levels that are valid on every cycle.
    logic        btn_start_stop;
    logic        btn_clear;
    logic        btn_lap;
    logic [31:0] num_to_display;
    logic        running;
    logic        tick_out;
    logic        wrap;
    logic [1:0]  state_dbg;

    modport master (
        output btn_start_stop, btn_clear, btn_lap,
        input  num_to_display, running, tick_out, wrap, state_dbg
    );

    modport slave (
        input  btn_start_stop, btn_clear, btn_lap,
        output num_to_display, running, tick_out, wrap, state_dbg
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Debounced push-button stopwatch producing a binary count for the 7-segment driver.
// Optional lap freeze is compiled in when STOPWATCH_COUNTER_LAP_EN is defined.

// One button front end: 2-FF synchronizer, level debounce, rising-edge press pulse.
module stopwatch_counter_btn #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          deb_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            // A single agreeing cycle restarts the stability count.
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            deb_q <= deb;
            press <= deb & ~deb_q;
        end
    end
endmodule

module stopwatch_counter #(
    parameter int TICK_DIV        = 100000000,
    parameter int MAX_COUNT       = 99999999,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_counter_if.slave sw
);
    localparam int CNT_W = 27;
    localparam int PW    = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX  = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [PW-1:0]    presc, presc_next;
    logic             tick_q, tick_next;
    logic             wrap_q, wrap_next;
    logic             ss_press;
    logic             clr_press;
    logic [CNT_W-1:0] display;

    stopwatch_counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
        .clk   (clk),
        .reset (reset),
        .btn   (sw.btn_start_stop),
        .press (ss_press)
    );

    stopwatch_counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (sw.btn_clear),
        .press (clr_press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            presc  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            presc  <= presc_next;
            tick_q <= tick_next;
            wrap_q <= wrap_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        presc_next = presc;
        tick_next  = 1'b0;
        wrap_next  = 1'b0;
        // Clear overrides everything, including a tick due on this edge.
        if (clr_press) begin
            state_next = ST_IDLE;
            count_next = '0;
            presc_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    count_next = '0;
                    presc_next = '0;
                    if (ss_press) state_next = ST_RUN;
                end
                ST_RUN: begin
                    // The prescaler advances on the leaving edge too, so a stop on a
                    // terminal cycle still takes its tick.
                    if (presc == PRESC_LAST) begin
                        presc_next = '0;
                        tick_next  = 1'b1;
                        if (count == COUNT_MAX) begin
                            count_next = '0;
                            wrap_next  = 1'b1;
                        end else begin
                            count_next = count + CNT_W'(1);
                        end
                    end else begin
                        presc_next = presc + PW'(1);
                    end
                    if (ss_press) state_next = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (ss_press) state_next = ST_RUN;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

`ifdef STOPWATCH_COUNTER_LAP_EN
    logic             lap_press;
    logic             frozen;
    logic [CNT_W-1:0] lap_reg;

    stopwatch_counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (sw.btn_lap),
        .press (lap_press)
    );

    // The freeze only affects what is shown; the live count keeps running.
    always_ff @(posedge clk) begin
        if (reset) begin
            frozen  <= 1'b0;
            lap_reg <= '0;
        end else if (clr_press) begin
            frozen <= 1'b0;
        end else if (lap_press && state != ST_IDLE) begin
            frozen <= ~frozen;
            if (!frozen) lap_reg <= count;
        end
    end

    assign display = frozen ? lap_reg : count;
`else
    logic unused_lap;
    assign unused_lap = sw.btn_lap;
    assign display    = count;
`endif

    assign sw.num_to_display = {{(32 - CNT_W){1'b0}}, display};
    assign sw.running        = (state == ST_RUN);
    assign sw.tick_out       = tick_q;
    assign sw.wrap           = wrap_q;
    assign sw.state_dbg      = state;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: a tick scoreboard fed by the stimulus
// thread and drained by a negedge monitor, plus direct latency/state checks.
module tb_stopwatch_counter;
    localparam int TICK_DIV  = 4;
    localparam int MAX_COUNT = 12;
    localparam int DEB       = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PAUSE = 2'd2;
`ifdef STOPWATCH_COUNTER_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stopwatch_counter_if sw_if ();

    stopwatch_counter #(
        .TICK_DIV        (TICK_DIV),
        .MAX_COUNT       (MAX_COUNT),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_if)
    );

    int          checks   = 0;
    int          failures = 0;
    bit          done     = 1'b0;
    logic [32:0] exp_q[$];   // {wrap, displayed value} per expected tick
    logic [32:0] exp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_tick(input logic w, input int v);
        exp_q.push_back({w, 32'(v)});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input string name);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sw_if.tick_out === 1'b1) break;
        end
        if (k == 40) begin
            checks++;
            failures++;
            $display("FAIL %s: got no tick expected tick within 40 cycles", name);
        end
    endtask

    // Negedges until running reaches level; 0 if it never does.
    task automatic wait_running(input logic level, output int edges);
        edges = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (sw_if.running === level) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic cycles_to_tick(output int gap);
        gap = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (sw_if.tick_out === 1'b1) begin
                gap = k;
                break;
            end
        end
    endtask

    // Monitor: every tick must match the head of the expected queue.
    always @(negedge clk) begin
        if (!done && reset === 1'b0) begin
            if (sw_if.tick_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tick: got tick display=%0d expected no tick", sw_if.num_to_display);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("tick_display", sw_if.num_to_display, exp_e[31:0]);
                    check("tick_wrap", 32'(sw_if.wrap), 32'(exp_e[32]));
                end
            end else if (sw_if.wrap !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL wrap_without_tick: got wrap=%b expected 0", sw_if.wrap);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        int g;
        reset = 1'b1;
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_clear      = 1'b0;
        sw_if.btn_lap        = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
        check("reset_display", sw_if.num_to_display, 0);
        check("reset_running", 32'(sw_if.running), 0);
        check("reset_tick", 32'(sw_if.tick_out), 0);
        check("reset_wrap", 32'(sw_if.wrap), 0);
        check("reset_state", 32'(sw_if.state_dbg), 32'(ST_IDLE));

        // Start, count up to MAX_COUNT and wrap.
        for (int v = 1; v <= 12; v++) push_tick(1'b0, v);
        push_tick(1'b1, 0);
        sw_if.btn_start_stop = 1'b1;
        wait_running(1'b1, e);
        check("start_latency", e, 6);
        sw_if.btn_start_stop = 1'b0;
        cycles_to_tick(g);
        check("first_tick_gap", g, 4);
        repeat (12) wait_tick("count_up");
        step(1);
        check("wrap_tick_one_cycle", 32'(sw_if.tick_out), 0);
        check("wrap_one_cycle", 32'(sw_if.wrap), 0);
        check("after_wrap_display", sw_if.num_to_display, 0);

        // Pause at count 5 with prescaler 2, glitch clear, resume.
        for (int v = 1; v <= 5; v++) push_tick(1'b0, v);
        repeat (4) wait_tick("to_four");
        sw_if.btn_start_stop = 1'b1;
        wait_running(1'b0, e);
        check("pause_latency", e, 6);
        check("pause_display", sw_if.num_to_display, 5);
        check("pause_state", 32'(sw_if.state_dbg), 32'(ST_PAUSE));
        sw_if.btn_start_stop = 1'b0;
        step(6);
        sw_if.btn_clear = 1'b1;
        step(1);
        sw_if.btn_clear = 1'b0;
        step(50);
        check("paused_hold_display", sw_if.num_to_display, 5);
        check("glitch_no_clear_state", 32'(sw_if.state_dbg), 32'(ST_PAUSE));
        push_tick(1'b0, 6);
        sw_if.btn_start_stop = 1'b1;
        wait_running(1'b1, e);
        check("resume_latency", e, 6);
        cycles_to_tick(g);
        check("resume_tick_gap", g, 2);
        sw_if.btn_start_stop = 1'b0;

        // Held clear during RUN at count 7.
        push_tick(1'b0, 7);
        step(1);
        sw_if.btn_clear = 1'b1;
        step(5);
        sw_if.btn_clear = 1'b0;
        step(3);
        check("clear_display", sw_if.num_to_display, 0);
        check("clear_running", 32'(sw_if.running), 0);
        check("clear_state", 32'(sw_if.state_dbg), 32'(ST_IDLE));

        // Clear and start_stop pulses on the same cycle while running.
        step(6);
        for (int v = 1; v <= 3; v++) push_tick(1'b0, v);
        sw_if.btn_start_stop = 1'b1;
        wait_running(1'b1, e);
        check("restart_latency", e, 6);
        sw_if.btn_start_stop = 1'b0;
        repeat (2) wait_tick("simul_pre");
        sw_if.btn_start_stop = 1'b1;
        sw_if.btn_clear      = 1'b1;
        step(5);
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_clear      = 1'b0;
        step(3);
        check("simul_display", sw_if.num_to_display, 0);
        check("simul_state", 32'(sw_if.state_dbg), 32'(ST_IDLE));
        step(12);
        check("simul_stays_idle", 32'(sw_if.running), 0);

        // Reset mid-run at count 9 with a start_stop pulse already pending.
        for (int v = 1; v <= 9; v++) push_tick(1'b0, v);
        sw_if.btn_start_stop = 1'b1;
        wait_running(1'b1, e);
        sw_if.btn_start_stop = 1'b0;
        repeat (8) wait_tick("to_eight");
        step(1);
        sw_if.btn_start_stop = 1'b1;
        step(5);
        check("pre_reset_display", sw_if.num_to_display, 9);
        reset = 1'b1;
        sw_if.btn_start_stop = 1'b0;
        step(1);
        check("midrun_reset_display", sw_if.num_to_display, 0);
        check("midrun_reset_running", 32'(sw_if.running), 0);
        check("midrun_reset_tick", 32'(sw_if.tick_out), 0);
        check("midrun_reset_state", 32'(sw_if.state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        step(12);
        check("pending_pulse_dropped", 32'(sw_if.running), 0);
        check("post_reset_display", sw_if.num_to_display, 0);

        // Lap at count 3, release at count 6.
        for (int v = 1; v <= 3; v++) push_tick(1'b0, v);
        for (int v = 4; v <= 6; v++) push_tick(1'b0, LAP ? 3 : v);
        sw_if.btn_start_stop = 1'b1;
        wait_running(1'b1, e);
        sw_if.btn_start_stop = 1'b0;
        repeat (2) wait_tick("lap_pre");
        step(1);
        sw_if.btn_lap = 1'b1;
        step(5);
        sw_if.btn_lap = 1'b0;
        repeat (2) wait_tick("lap_frozen_ticks");
        step(1);
        sw_if.btn_lap = 1'b1;
        step(5);
        check("lap_before_release", sw_if.num_to_display, LAP ? 3 : 6);
        sw_if.btn_lap = 1'b0;
        step(1);
        check("lap_released", sw_if.num_to_display, 6);

        done = 1'b1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
